div_issue_ctrl: RTL and testbench
=================================

Name: div_issue_ctrl

Overview:
- Execute-stage initiator for the iterative divider's Start/Enable/Annul/Ready handshake.
- Issues DIV/DIVU to the divider, holds operands stable and stalls the pipeline until Ready.
- Commits {remainder, quotient} into HI/LO, acknowledges the divider, and cancels in-flight divides on pipeline flush.
- Also owns HI/LO writes from MTHI/MTLO.

Parameters:
WATCHDOG, 6'd32, cycles in WAIT without div_ready before a forced annul and error flag

Ports:
clk  in  1  core clock
rst  in  1  asynchronous active-high reset
ex_valid  in  1  EX-stage instruction valid
ex_op  in  3  000 none, 001 DIV, 010 DIVU, 011 MTHI, 100 MTLO, others treated as none
ex_rs  in  32  dividend / MTHI,MTLO source
ex_rt  in  32  divisor
flush  in  1  pipeline flush (EX instruction and any in-flight divide are cancelled)
stall  out  1  freeze IF..EX
div_signed  out  1  to divider Signed
div_a  out  32  to divider A
div_b  out  32  to divider B
div_start  out  1  to divider Start
div_enable  out  1  to divider Enable (result acknowledge)
div_annul  out  1  to divider Annul
div_result  in  64  from divider Result, {remainder[63:32], quotient[31:0]}
div_ready  in  1  from divider Ready
hi  out  32  HI register
lo  out  32  LO register
div_err  out  1  sticky watchdog-timeout flag

Behaviour:
- Reset (async, rst=1):
  - state=IDLE.
  - hi, lo, div_a, div_b = 0.
  - div_signed, div_start, div_enable, div_annul, div_err = 0.
  - Watchdog counter = 0.
- Output registration:
  - All div_* outputs and hi/lo are registered.
  - stall is combinational from state and EX inputs.
- States: IDLE, WAIT, ACK.
- div_op = ex_valid & ~flush & (ex_op==DIV | ex_op==DIVU).
- IDLE:
  - div_op with ex_rt != 0:
    - Latch div_a=ex_rs, div_b=ex_rt, div_signed=(ex_op==DIV).
    - Clear div_err and the counter; go to WAIT.
    - stall=1 this cycle.
  - div_op with ex_rt == 0: no issue, HI/LO unchanged, no stall (architecturally undefined result).
- WAIT:
  - div_start=1 for the whole state.
  - div_a/div_b/div_signed held constant.
  - stall=1; counter increments each cycle.
  - div_ready=1 and no flush: hi<=div_result[63:32], lo<=div_result[31:0]; go to ACK; stall drops in this same cycle so the divide retires.
  - flush=1 (including simultaneously with div_ready): div_annul=1 for exactly one cycle, div_start=0, HI/LO unchanged, go to IDLE. Flush has priority over ready.
  - Counter reaches WATCHDOG-1 without ready: div_annul=1 one cycle, div_err=1, HI/LO unchanged, go to IDLE, stall releases.
- ACK (exactly one cycle):
  - div_start=0, div_enable=1 (divider clears Ready).
  - A new div_op is stalled this cycle and issues from IDLE next cycle.
  - MTHI/MTLO proceed.
  - Next state is IDLE.
- MTHI/MTLO:
  - ex_valid & ~flush & op match: hi<=ex_rs or lo<=ex_rs in any state except WAIT. In WAIT the pipeline is stalled, so the write cannot occur.
  - If an MTHI/MTLO and a WAIT->ACK result commit fall on the same edge, the divider result wins: the stalled MT* has not yet reached EX, so this cannot arise legally.
- div_annul and div_enable are never high together.
- div_start never rises in the same cycle as div_annul.
- Back-to-back DIVs: minimum spacing is IDLE->WAIT..ACK->IDLE. At least one idle cycle between start fall and the next start rise is guaranteed.
- rst mid-WAIT: state returns to IDLE immediately. The divider shares rst and resets itself; no annul pulse is required.
- hi/lo are visible to MFHI/MFLO the cycle after commit. Bypass is handled by the forwarding unit.

Test Plan:
- Bench divider model has fixed 6-cycle Ready latency.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> stall high 7 cycles, div_start high 6 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF, div_enable pulse 1 cycle, div_err=0.
- DIVU rs=100, rt=7 -> lo=14, hi=2. A DIVU issued in the ACK cycle (rs=9, rt=3) is stalled 1 extra cycle, then lo=3, hi=0.
- DIV rs=50, rt=5; flush at WAIT cycle 3 -> div_annul single pulse, div_start low, hi/lo keep prior values, state IDLE, stall low.
- DIV rt=0 with hi=0x11, lo=0x22 -> no div_start, no stall, hi=0x11, lo=0x22.
- Divider model never asserts Ready, WATCHDOG=32 -> after 31 WAIT cycles: div_annul pulse, div_err=1, stall released. The next valid DIV clears div_err.
- MTHI rs=0xDEADBEEF in IDLE -> hi=0xDEADBEEF next cycle. Assert rst during WAIT -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/div_issue_ctrl.sv
// Execute-stage initiator for the iterative divider handshake (Start/Enable/Annul/Ready).
// Issues DIV/DIVU, stalls the pipeline until Ready, commits into HI/LO and handles MTHI/MTLO.
module div_issue_ctrl #(
  parameter logic [5:0] WATCHDOG = 6'd32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [2:0]  ex_op,
  input  logic [31:0] ex_rs,
  input  logic [31:0] ex_rt,
  input  logic        flush,
  output logic        stall,
  output logic        div_signed,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  output logic        div_start,
  output logic        div_enable,
  output logic        div_annul,
  input  logic [63:0] div_result,
  input  logic        div_ready,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_err
);

  localparam logic [2:0] OP_DIV  = 3'b001;
  localparam logic [2:0] OP_DIVU = 3'b010;
  localparam logic [2:0] OP_MTHI = 3'b011;
  localparam logic [2:0] OP_MTLO = 3'b100;

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t      state, state_nx;
  logic [5:0]  wd_cnt;
  logic [5:0]  wd_inc;
  logic        ex_live;
  logic        div_op;
  logic        mthi_op;
  logic        mtlo_op;
  logic        issue;
  logic        commit;
  logic        cancel;
  logic        timeout;

  assign ex_live = ex_valid & ~flush;
  assign div_op  = ex_live & ((ex_op == OP_DIV) | (ex_op == OP_DIVU));
  assign mthi_op = ex_live & (ex_op == OP_MTHI);
  assign mtlo_op = ex_live & (ex_op == OP_MTLO);
  assign wd_inc  = wd_cnt + 6'd1;

  // Flush beats ready in WAIT; the watchdog only fires when neither is present.
  always_comb begin
    state_nx = state;
    stall    = 1'b0;
    issue    = 1'b0;
    commit   = 1'b0;
    cancel   = 1'b0;
    timeout  = 1'b0;
    case (state)
      IDLE: begin
        if (div_op && (ex_rt != 32'd0)) begin
          issue    = 1'b1;
          stall    = 1'b1;
          state_nx = WAIT;
        end
      end
      WAIT: begin
        if (flush) begin
          cancel   = 1'b1;
          state_nx = IDLE;
        end else if (div_ready) begin
          commit   = 1'b1;
          state_nx = ACK;
        end else if (wd_inc == WATCHDOG - 6'd1) begin
          timeout  = 1'b1;
          state_nx = IDLE;
        end else begin
          stall    = 1'b1;
        end
      end
      ACK: begin
        stall    = div_op;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Handshake outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      div_a      <= 32'd0;
      div_b      <= 32'd0;
      div_signed <= 1'b0;
      div_start  <= 1'b0;
      div_enable <= 1'b0;
      div_annul  <= 1'b0;
      div_err    <= 1'b0;
      wd_cnt     <= 6'd0;
      hi         <= 32'd0;
      lo         <= 32'd0;
    end else begin
      state      <= state_nx;
      div_start  <= (state_nx == WAIT);
      div_enable <= commit;
      div_annul  <= cancel | timeout;
      if (issue) begin
        div_a      <= ex_rs;
        div_b      <= ex_rt;
        div_signed <= (ex_op == OP_DIV);
        div_err    <= 1'b0;
        wd_cnt     <= 6'd0;
      end else begin
        if (state == WAIT) begin
          wd_cnt <= wd_inc;
        end
        if (timeout) begin
          div_err <= 1'b1;
        end
      end
      if (commit) begin
        hi <= div_result[63:32];
        lo <= div_result[31:0];
      end else if (state != WAIT) begin
        if (mthi_op) begin
          hi <= ex_rs;
        end
        if (mtlo_op) begin
          lo <= ex_rs;
        end
      end
    end
  end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl with a fixed-latency divider model.
module tb_div_issue_ctrl;

  localparam logic [2:0] OP_NONE = 3'b000;
  localparam logic [2:0] OP_DIV  = 3'b001;
  localparam logic [2:0] OP_DIVU = 3'b010;
  localparam logic [2:0] OP_MTHI = 3'b011;
  localparam logic [2:0] OP_MTLO = 3'b100;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic [2:0]  ex_op;
  logic [31:0] ex_rs;
  logic [31:0] ex_rt;
  logic        flush;
  logic        stall;
  logic        div_signed;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic        div_start;
  logic        div_enable;
  logic        div_annul;
  logic [63:0] div_result;
  logic        div_ready;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_err;

  int checkCount = 0;
  int errorCount = 0;
  int stallCycles;
  int startCycles;

  logic [3:0] modelCnt;
  logic       modelReadyEn;

  div_issue_ctrl #(.WATCHDOG(6'd32)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_op(ex_op), .ex_rs(ex_rs),
    .ex_rt(ex_rt), .flush(flush), .stall(stall), .div_signed(div_signed),
    .div_a(div_a), .div_b(div_b), .div_start(div_start), .div_enable(div_enable),
    .div_annul(div_annul), .div_result(div_result), .div_ready(div_ready),
    .hi(hi), .lo(lo), .div_err(div_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Divider model: Ready after Start has been seen high for 6 edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      modelCnt <= 4'd0;
    end else if (!div_start) begin
      modelCnt <= 4'd0;
    end else if (modelCnt < 4'd6) begin
      modelCnt <= modelCnt + 4'd1;
    end
  end

  assign div_ready = modelReadyEn & div_start & (modelCnt == 4'd6);

  always_comb begin
    div_result = 64'd0;
    if (div_b != 32'd0) begin
      if (div_signed) begin
        div_result[31:0]  = $signed(div_a) / $signed(div_b);
        div_result[63:32] = $signed(div_a) % $signed(div_b);
      end else begin
        div_result[31:0]  = div_a / div_b;
        div_result[63:32] = div_a % div_b;
      end
    end
  end

  task automatic applyStimulus(input logic v, input logic [2:0] op, input logic [31:0] rs,
                               input logic [31:0] rt, input logic fl);
    ex_valid = v;
    ex_op    = op;
    ex_rs    = rs;
    ex_rt    = rt;
    flush    = fl;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) else begin
      errorCount++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Counts stall/start cycles from the current sample point until stall drops.
  task automatic waitRelease(output int nStall, output int nStart);
    nStall = 0;
    nStart = 0;
    for (int i = 0; i < 60; i++) begin
      if (stall) nStall++;
      if (div_start && !div_ready) nStart++;
      if (!stall) break;
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    rst = 1'b1;
    modelReadyEn = 1'b1;
    applyStimulus(1'b0, OP_NONE, 32'd0, 32'd0, 1'b0);
    #3;
    checkOutput("reset_hi", hi, 32'd0);
    checkOutput("reset_lo", lo, 32'd0);
    checkOutput("reset_a", div_a, 32'd0);
    checkOutput("reset_b", div_b, 32'd0);
    checkOutput("reset_ctl", {27'd0, div_signed, div_start, div_enable, div_annul, div_err}, 32'd0);
    checkOutput("reset_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] signed divide -7 / 2");
    nextCycle(); applyStimulus(1'b1, OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b0); settle();
    waitRelease(stallCycles, startCycles);
    checkOutput("div1_stall_cycles", stallCycles, 32'd7);
    checkOutput("div1_start_cycles", startCycles, 32'd6);
    nextCycle(); applyStimulus(1'b0, OP_NONE, 32'd0, 32'd0, 1'b0); settle();
    checkOutput("div1_lo", lo, 32'hFFFFFFFD);
    checkOutput("div1_hi", hi, 32'hFFFFFFFF);
    checkOutput("div1_enable", {31'd0, div_enable}, 32'd1);
    checkOutput("div1_start_ack", {31'd0, div_start}, 32'd0);
    checkOutput("div1_err", {31'd0, div_err}, 32'd0);

    $display("[TB] unsigned divide 100 / 7, then 9 / 3 issued in ACK");
    nextCycle(); applyStimulus(1'b1, OP_DIVU, 32'd100, 32'd7, 1'b0); settle();
    checkOutput("div1_enable_pulse", {31'd0, div_enable}, 32'd0);
    waitRelease(stallCycles, startCycles);
    checkOutput("divu1_stall_cycles", stallCycles, 32'd7);
    nextCycle(); applyStimulus(1'b1, OP_DIVU, 32'd9, 32'd3, 1'b0); settle();
    checkOutput("divu1_lo", lo, 32'd14);
    checkOutput("divu1_hi", hi, 32'd2);
    checkOutput("divu2_ack_stall", {31'd0, stall}, 32'd1);
    checkOutput("divu1_enable", {31'd0, div_enable}, 32'd1);
    nextCycle(); settle();
    checkOutput("divu2_idle_enable", {31'd0, div_enable}, 32'd0);
    waitRelease(stallCycles, startCycles);
    checkOutput("divu2_stall_cycles", stallCycles, 32'd7);
    nextCycle(); applyStimulus(1'b0, OP_NONE, 32'd0, 32'd0, 1'b0); settle();
    checkOutput("divu2_lo", lo, 32'd3);
    checkOutput("divu2_hi", hi, 32'd0);

    $display("[TB] flush in WAIT cycle 3");
    nextCycle(); applyStimulus(1'b1, OP_DIV, 32'd50, 32'd5, 1'b0); settle();
    nextCycle(); settle();
    checkOutput("flush_a", div_a, 32'd50);
    checkOutput("flush_b", div_b, 32'd5);
    checkOutput("flush_signed", {31'd0, div_signed}, 32'd1);
    nextCycle(); settle();
    nextCycle(); applyStimulus(1'b1, OP_DIV, 32'd50, 32'd5, 1'b1); settle();
    checkOutput("flush_start_w3", {31'd0, div_start}, 32'd1);
    nextCycle(); applyStimulus(1'b0, OP_NONE, 32'd0, 32'd0, 1'b0); settle();
    checkOutput("flush_annul", {31'd0, div_annul}, 32'd1);
    checkOutput("flush_start", {31'd0, div_start}, 32'd0);
    checkOutput("flush_stall", {31'd0, stall}, 32'd0);
    checkOutput("flush_hi", hi, 32'd0);
    checkOutput("flush_lo", lo, 32'd3);
    nextCycle(); settle();
    checkOutput("flush_annul_pulse", {31'd0, div_annul}, 32'd0);

    $display("[TB] flush coinciding with ready");
    nextCycle(); applyStimulus(1'b1, OP_DIV, 32'd50, 32'd5, 1'b0); settle();
    for (int i = 0; i < 6; i++) begin
      nextCycle(); settle();
    end
    nextCycle(); applyStimulus(1'b1, OP_DIV, 32'd50, 32'd5, 1'b1); settle();
    nextCycle(); applyStimulus(1'b0, OP_NONE, 32'd0, 32'd0, 1'b0); settle();
    checkOutput("flushrdy_annul", {31'd0, div_annul}, 32'd1);
    checkOutput("flushrdy_enable", {31'd0, div_enable}, 32'd0);
    checkOutput("flushrdy_hi", hi, 32'd0);
    checkOutput("flushrdy_lo", lo, 32'd3);

    $display("[TB] MTHI/MTLO and divide by zero");
    nextCycle(); applyStimulus(1'b1, OP_MTHI, 32'h11, 32'd0, 1'b0); settle();
    nextCycle(); applyStimulus(1'b1, OP_MTLO, 32'h22, 32'd0, 1'b0); settle();
    checkOutput("mthi_hi", hi, 32'h11);
    nextCycle(); applyStimulus(1'b1, OP_DIV, 32'h1234, 32'd0, 1'b0); settle();
    checkOutput("mtlo_lo", lo, 32'h22);
    checkOutput("divzero_stall", {31'd0, stall}, 32'd0);
    nextCycle(); applyStimulus(1'b0, OP_NONE, 32'd0, 32'd0, 1'b0); settle();
    checkOutput("divzero_start", {31'd0, div_start}, 32'd0);
    checkOutput("divzero_hi", hi, 32'h11);
    checkOutput("divzero_lo", lo, 32'h22);

    $display("[TB] watchdog timeout");
    modelReadyEn = 1'b0;
    nextCycle(); applyStimulus(1'b1, OP_DIV, 32'd7, 32'd1, 1'b0); settle();
    waitRelease(stallCycles, startCycles);
    checkOutput("wd_stall_cycles", stallCycles, 32'd31);
    checkOutput("wd_start_cycles", startCycles, 32'd31);
    nextCycle(); applyStimulus(1'b0, OP_NONE, 32'd0, 32'd0, 1'b0); settle();
    checkOutput("wd_annul", {31'd0, div_annul}, 32'd1);
    checkOutput("wd_err", {31'd0, div_err}, 32'd1);
    checkOutput("wd_start", {31'd0, div_start}, 32'd0);
    checkOutput("wd_stall", {31'd0, stall}, 32'd0);
    checkOutput("wd_hi", hi, 32'h11);
    checkOutput("wd_lo", lo, 32'h22);
    nextCycle(); settle();
    checkOutput("wd_annul_pulse", {31'd0, div_annul}, 32'd0);
    checkOutput("wd_err_sticky", {31'd0, div_err}, 32'd1);
    modelReadyEn = 1'b1;
    nextCycle(); applyStimulus(1'b1, OP_DIV, 32'd7, 32'd1, 1'b0); settle();
    checkOutput("wd_reissue_stall", {31'd0, stall}, 32'd1);
    nextCycle(); settle();
    checkOutput("wd_err_cleared", {31'd0, div_err}, 32'd0);
    waitRelease(stallCycles, startCycles);
    checkOutput("wd_reissue_wait", stallCycles, 32'd6);
    nextCycle(); applyStimulus(1'b0, OP_NONE, 32'd0, 32'd0, 1'b0); settle();
    checkOutput("wd_reissue_lo", lo, 32'd7);
    checkOutput("wd_reissue_hi", hi, 32'd0);

    $display("[TB] MTHI in IDLE and reset during WAIT");
    nextCycle(); applyStimulus(1'b1, OP_MTHI, 32'hDEADBEEF, 32'd0, 1'b0); settle();
    nextCycle(); applyStimulus(1'b0, OP_NONE, 32'd0, 32'd0, 1'b0); settle();
    checkOutput("mthi2_hi", hi, 32'hDEADBEEF);
    checkOutput("mthi2_lo", lo, 32'd7);
    nextCycle(); applyStimulus(1'b1, OP_DIV, 32'd100, 32'd3, 1'b0); settle();
    nextCycle(); settle();
    nextCycle(); settle();
    checkOutput("rst_pre_start", {31'd0, div_start}, 32'd1);
    applyStimulus(1'b0, OP_NONE, 32'd0, 32'd0, 1'b0);
    #1 rst = 1'b1;
    #1;
    checkOutput("rst_async_hi", hi, 32'd0);
    checkOutput("rst_async_lo", lo, 32'd0);
    checkOutput("rst_async_a", div_a, 32'd0);
    checkOutput("rst_async_b", div_b, 32'd0);
    checkOutput("rst_async_ctl", {27'd0, div_signed, div_start, div_enable, div_annul, div_err}, 32'd0);
    checkOutput("rst_async_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    nextCycle(); settle();
    checkOutput("rst_idle_start", {31'd0, div_start}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
